// File: rtl/wb_spi_dac_ctl.sv
// Wishbone-sequenced 24-bit SPI DAC shifter with one pending word, programmable SCLK divider and status.
// Optional: define DAC_INIT_EN to transmit RESET_WORD once automatically after reset.
module wb_spi_dac_ctl #(
  parameter int          DIV_WIDTH   = 8,
  parameter int          DIV_DEFAULT = 10,
  parameter int          SYNC_GAP    = 5,
  parameter logic [23:0] RESET_WORD  = 24'h007F22
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic [31:0] o_wb_data,
  output logic        o_spi_sclk,
  output logic        o_spi_mosi,
  output logic        o_spi_sync_n,
  output logic        o_busy
);

  localparam int GAP_HALVES = 2 * SYNC_GAP;
  localparam int GW         = $clog2(GAP_HALVES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t               state_reg, state_next;
  logic                 ack_reg;
  logic [31:0]          rdata_reg;
  logic [23:0]          data_reg;
  logic [DIV_WIDTH-1:0] div_reg;
  logic                 pending_reg, pending_next;
  logic                 ovr_reg, ovr_next;
  logic [23:0]          shift_reg;
  logic [DIV_WIDTH-1:0] div_lat_reg;
  logic [DIV_WIDTH-1:0] div_cnt_reg;
  logic [4:0]           bit_cnt_reg;
  logic [GW-1:0]        gap_cnt_reg;
  logic                 sclk_reg;
  logic [31:0]          rd_word;
  logic                 wb_acc, data_wr, data_full_wr, ovr_clr, div_wr, consume, tick, framing;
  logic                 unused_bits;

  assign wb_acc       = i_wb_cyc & i_wb_stb;
  assign data_wr      = wb_acc & i_wb_we & (i_wb_addr == 2'd0);
  assign data_full_wr = data_wr & (&i_wb_sel[2:0]);
  assign div_wr       = wb_acc & i_wb_we & (i_wb_addr == 2'd2);
  assign ovr_clr      = wb_acc & i_wb_we & (i_wb_addr == 2'd1) & i_wb_sel[0] & i_wb_data[2];
  assign consume      = (state_reg == IDLE) & pending_reg;
  assign tick         = (div_cnt_reg == div_lat_reg);
  assign framing      = (state_reg == LOAD) | (state_reg == SHIFT);
  assign unused_bits  = &{1'b0, i_wb_data[31:24], i_wb_sel[3]};

  assign o_wb_stall   = 1'b0;
  assign o_wb_ack     = ack_reg;
  assign o_wb_data    = rdata_reg;
  assign o_spi_sclk   = sclk_reg;
  assign o_spi_mosi   = framing & shift_reg[23];
  assign o_spi_sync_n = ~framing;
  assign o_busy       = (state_reg != IDLE);

`ifdef DAC_INIT_EN
  logic init_reg;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) init_reg <= 1'b1;
    else          init_reg <= 1'b0;
  end
`endif

  // A host write landing in the consume cycle wins, so the new word stays pending without OVR.
  always_comb begin
    pending_next = pending_reg;
    ovr_next     = ovr_reg;
    if (consume)      pending_next = 1'b0;
    if (data_full_wr) pending_next = 1'b1;
`ifdef DAC_INIT_EN
    if (init_reg)     pending_next = 1'b1;
`endif
    if (ovr_clr)      ovr_next = 1'b0;
    if (data_full_wr && pending_reg && !consume) ovr_next = 1'b1;
  end

  always_comb begin
    rd_word = '0;
    case (i_wb_addr)
      2'd0:    rd_word[23:0]          = data_reg;
      2'd1:    rd_word[2:0]           = {ovr_reg, pending_reg, o_busy};
      2'd2:    rd_word[DIV_WIDTH-1:0] = div_reg;
      default: rd_word                = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ack_reg     <= 1'b0;
      rdata_reg   <= '0;
      data_reg    <= RESET_WORD;
      div_reg     <= DIV_WIDTH'(DIV_DEFAULT);
      pending_reg <= 1'b0;
      ovr_reg     <= 1'b0;
    end else begin
      ack_reg     <= wb_acc;
      rdata_reg   <= (wb_acc && !i_wb_we) ? rd_word : '0;
      pending_reg <= pending_next;
      ovr_reg     <= ovr_next;
      if (data_wr)
        for (int b = 0; b < 3; b++)
          if (i_wb_sel[b]) data_reg[8*b +: 8] <= i_wb_data[8*b +: 8];
      if (div_wr)
        for (int b = 0; b < DIV_WIDTH; b++)
          if (i_wb_sel[b/8]) div_reg[b] <= i_wb_data[b];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // SHIFT ends on the low half-period that follows the 24th falling edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (pending_reg) state_next = LOAD;
      LOAD:  if (tick) state_next = SHIFT;
      SHIFT: if (tick && !sclk_reg && bit_cnt_reg == 5'd24) state_next = GAP;
      GAP:   if (tick && gap_cnt_reg == GW'(GAP_HALVES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift_reg   <= '0;
      div_lat_reg <= DIV_WIDTH'(DIV_DEFAULT);
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
    end else begin
      div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          sclk_reg    <= 1'b0;
          div_cnt_reg <= '0;
          bit_cnt_reg <= '0;
          gap_cnt_reg <= '0;
          if (pending_reg) begin
            shift_reg   <= data_reg;
            div_lat_reg <= div_reg;
          end
        end
        LOAD: if (tick) sclk_reg <= 1'b1;
        SHIFT: if (tick) begin
          if (sclk_reg) begin
            sclk_reg  <= 1'b0;
            shift_reg <= {shift_reg[22:0], 1'b0};
            if (bit_cnt_reg != 5'd24) bit_cnt_reg <= bit_cnt_reg + 5'd1;
          end else if (bit_cnt_reg != 5'd24) begin
            sclk_reg <= 1'b1;
          end
        end
        GAP: begin
          sclk_reg <= 1'b0;
          if (tick) gap_cnt_reg <= gap_cnt_reg + 1'b1;
        end
        default: sclk_reg <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_spi_dac_ctl.sv
// Directed bench for wb_spi_dac_ctl: register table, frame capture, overwrite, divider change, reset abort.
module tb_wb_spi_dac_ctl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [1:0]  i_wb_addr = '0;
  logic [31:0] i_wb_data = '0;
  logic [3:0]  i_wb_sel = '0;
  logic        o_wb_stall, o_wb_ack, o_spi_sclk, o_spi_mosi, o_spi_sync_n, o_busy;
  logic [31:0] o_wb_data;

  wb_spi_dac_ctl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr),
    .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel), .o_wb_data(o_wb_data), .o_spi_sclk(o_spi_sclk),
    .o_spi_mosi(o_spi_mosi), .o_spi_sync_n(o_spi_sync_n), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [23:0] word; int bits; int len; int hi; } frame_t;
  typedef struct { logic we; logic [1:0] addr; logic [31:0] wdata; logic [3:0] sel; logic [31:0] exp; } vec_t;

  frame_t      frames[$];
  int          n_checks = 0, n_fail = 0;
  int          mon_bits = 0;

`ifdef DAC_INIT_EN
  localparam logic [31:0] EXP_STATUS_AFTER_RST = 32'h1;
`else
  localparam logic [31:0] EXP_STATUS_AFTER_RST = 32'h0;
`endif

  // Frame monitor: captures MOSI on SCLK rising edges while sync_n is low.
  initial begin
    int cyc_cnt = 0, start = 0, hi_run = 0, last_hi = 0;
    logic prev_busy = 1'b0, prev_sclk = 1'b0;
    logic [23:0] word = '0;
    frame_t f;
    forever begin
      @(posedge i_clk);
      cyc_cnt++;
      if (!i_rst_n) begin
        prev_busy = 1'b0; prev_sclk = 1'b0; mon_bits = 0; hi_run = 0;
      end else begin
        if (o_busy && !prev_busy) begin start = cyc_cnt; mon_bits = 0; word = '0; end
        if (o_spi_sclk && !prev_sclk && !o_spi_sync_n) begin
          word = {word[22:0], o_spi_mosi};
          mon_bits++;
        end
        if (o_spi_sclk) hi_run++;
        else begin
          if (prev_sclk) last_hi = hi_run;
          hi_run = 0;
        end
        if (!o_busy && prev_busy) begin
          f.word = word; f.bits = mon_bits; f.len = cyc_cnt - start; f.hi = last_hi;
          frames.push_back(f);
        end
        prev_busy = o_busy;
        prev_sclk = o_spi_sclk;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                     input logic [3:0] sel, output logic [31:0] rdata);
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_addr = addr; i_wb_data = wdata; i_wb_sel = sel;
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    chk("ack", {31'b0, o_wb_ack}, 32'h1);
    rdata = o_wb_data;
    $display("bus we=%0d addr=%0d wdata=0x%08h sel=%h rdata=0x%08h", we, addr, wdata, sel, rdata);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    bus(1'b1, addr, wdata, 4'hF, d);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, addr, 32'h0, 4'hF, d);
    chk(name, d, exp);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (frames.size() < n && c < budget) begin
      @(posedge i_clk); c++;
    end
    #1;
    chk("frame_timeout", frames.size(), n);
  endtask

  task automatic chk_frame(input string name, input int idx, input logic [23:0] word,
                           input int len, input int hi);
    if (frames.size() > idx) begin
      $display("frame %s word=0x%06h bits=%0d len=%0d hi=%0d", name, frames[idx].word,
               frames[idx].bits, frames[idx].len, frames[idx].hi);
      chk({name, "_word"}, {8'h0, frames[idx].word}, {8'h0, word});
      chk({name, "_bits"}, frames[idx].bits, 24);
      chk({name, "_len"}, frames[idx].len, len);
      chk({name, "_hi"}, frames[idx].hi, hi);
    end else begin
      chk({name, "_missing"}, frames.size(), idx + 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[15];
    int c;
    logic [31:0] exp_b2b[4];
    vecs[0]  = '{1'b0, 2'd0, 32'h0,        4'hF, 32'h007F22};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,        4'hF, 32'h0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,        4'hF, 32'd10};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,        4'hF, 32'h0};
    vecs[4]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[5]  = '{1'b0, 2'd3, 32'h0,        4'hF, 32'h0};
    vecs[6]  = '{1'b1, 2'd2, 32'h000001FF, 4'h1, 32'h0};
    vecs[7]  = '{1'b0, 2'd2, 32'h0,        4'hF, 32'h000000FF};
    vecs[8]  = '{1'b1, 2'd2, 32'h00000002, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, 2'd2, 32'h0,        4'hF, 32'h2};
    vecs[10] = '{1'b1, 2'd0, 32'hFFFFFFCD, 4'h1, 32'h0};
    vecs[11] = '{1'b0, 2'd0, 32'h0,        4'hF, 32'h007FCD};
    vecs[12] = '{1'b1, 2'd0, 32'h0000AB00, 4'h6, 32'h0};
    vecs[13] = '{1'b0, 2'd0, 32'h0,        4'hF, 32'h00ABCD};
    vecs[14] = '{1'b0, 2'd1, 32'h0,        4'hF, 32'h0};

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ack", {31'b0, o_wb_ack}, 32'h0);
    chk("rst_data", o_wb_data, 32'h0);
    chk("rst_sclk", {31'b0, o_spi_sclk}, 32'h0);
    chk("rst_mosi", {31'b0, o_spi_mosi}, 32'h0);
    chk("rst_sync_n", {31'b0, o_spi_sync_n}, 32'h1);
    chk("rst_busy", {31'b0, o_busy}, 32'h0);
    chk("rst_stall", {31'b0, o_wb_stall}, 32'h0);
    i_rst_n = 1'b1;

`ifdef DAC_INIT_EN
    wait_frames(1, 1000);
    chk_frame("init", 0, 24'h007F22, 649, 11);
`else
    repeat (700) @(posedge i_clk);
    #1;
    chk("no_init_frame", frames.size(), 0);
`endif
    frames.delete();

    // Register table
    for (int i = 0; i < 15; i++) begin
      logic [31:0] d;
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel, d);
      if (!vecs[i].we) chk($sformatf("vec%0d", i), d, vecs[i].exp);
    end
    repeat (20) @(posedge i_clk);
    #1;
    chk("partial_no_frame", frames.size(), 0);

    // Basic frame at DIV=2, sel[2:0] full
    begin
      logic [31:0] d;
      bus(1'b1, 2'd0, 32'h0000ABCD, 4'h7, d);
    end
    wait_frames(1, 400);
    chk_frame("basic", 0, 24'h00ABCD, 177, 3);
    frames.delete();

    // Overwrite of pending word during a frame
    wr(2'd0, 32'h005A5A5A);
    repeat (20) @(posedge i_clk);
    rd_chk("busy_status", 2'd1, 32'h1);
    wr(2'd0, 32'h00111111);
    wr(2'd0, 32'h00222222);
    rd_chk("ovr_status", 2'd1, 32'h7);
    wr(2'd1, 32'h4);
    rd_chk("ovr_cleared", 2'd1, 32'h3);
    wait_frames(2, 1000);
    chk_frame("ovr_a", 0, 24'h5A5A5A, 177, 3);
    chk_frame("ovr_b", 1, 24'h222222, 177, 3);
    frames.delete();

    // DIV change mid-frame applies to the next frame only
    wr(2'd0, 32'h003C3C3C);
    repeat (10) @(posedge i_clk);
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h000F0F0F);
    wait_frames(2, 1000);
    chk_frame("div_old", 0, 24'h3C3C3C, 177, 3);
    chk_frame("div_new", 1, 24'h0F0F0F, 59, 1);
    frames.delete();

    // Reset in the middle of a frame
    wr(2'd2, 32'h2);
    wr(2'd0, 32'h00123456);
    c = 0;
    while (mon_bits != 12 && c < 400) begin
      @(posedge i_clk); #1; c++;
    end
    chk("bit12_reached", mon_bits, 12);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    chk("abort_sync_n", {31'b0, o_spi_sync_n}, 32'h1);
    chk("abort_sclk", {31'b0, o_spi_sclk}, 32'h0);
    chk("abort_mosi", {31'b0, o_spi_mosi}, 32'h0);
    chk("abort_busy", {31'b0, o_busy}, 32'h0);
    i_rst_n = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    chk("abort_no_frame", frames.size(), 0);

    // Back-to-back reads of all four addresses
    exp_b2b[0] = 32'h007F22;
    exp_b2b[1] = EXP_STATUS_AFTER_RST;
    exp_b2b[2] = 32'd10;
    exp_b2b[3] = 32'h0;
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_sel = 4'hF; i_wb_addr = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge i_clk); #1;
      chk($sformatf("b2b_ack%0d", i - 1), {31'b0, o_wb_ack}, 32'h1);
      chk($sformatf("b2b_stall%0d", i - 1), {31'b0, o_wb_stall}, 32'h0);
      chk($sformatf("b2b_data%0d", i - 1), o_wb_data, exp_b2b[i-1]);
      $display("b2b read addr=%0d rdata=0x%08h", i - 1, o_wb_data);
      if (i < 4) i_wb_addr = 2'(i);
      else begin i_wb_cyc = 1'b0; i_wb_stb = 1'b0; end
    end
    @(posedge i_clk); #1;
    chk("b2b_ack_end", {31'b0, o_wb_ack}, 32'h0);

`ifdef DAC_INIT_EN
    wait_frames(1, 1000);
    chk_frame("init_after_abort", 0, 24'h007F22, 649, 11);
    repeat (800) @(posedge i_clk);
    #1;
    chk("init_once", frames.size(), 1);
`else
    repeat (800) @(posedge i_clk);
    #1;
    chk("idle_after_abort", frames.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
